// File: rtl/rr_burst_sched_pkg.sv
// ----------------------------------------------------------------------------
// rr_burst_sched_pkg
//   Shared types, defaults and helpers for the round-robin burst scheduler.
//   - state_e        : scheduler FSM states (IDLE, BURST)
//   - DEF_MAX_BEATS  : default beat limit per grant
//   - DEF_TIMEOUT    : default stall limit (GRANT_TIMEOUT_EN builds only)
//   - MAX_N          : widest one-hot vector onehot_to_idx accepts
//   - onehot_to_idx  : one-hot vector -> bit index
// ----------------------------------------------------------------------------
package rr_burst_sched_pkg;

   localparam int DEF_MAX_BEATS = 16;
   localparam int DEF_TIMEOUT   = 64;
   localparam int MAX_N         = 64;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   // OR together the indices of all set bits; for a one-hot input this is
   // exactly the index of the single set bit, and it maps to a shallow
   // OR tree rather than a priority chain.
   function automatic int onehot_to_idx(input logic [MAX_N-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_N; i++) begin
         if (oh[i]) begin
            idx = idx | i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_burst_scheduler_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Purely combinational rotating-priority picker. Searches req upward
//   starting at index ptr, wrapping from N-1 to 0; the first set bit wins.
//   Ports:
//     req    in  [N-1:0]          request vector
//     ptr    in  [$clog2(N)-1:0]  highest-priority index (must be < N)
//     win_oh out [N-1:0]          one-hot winner (zero when nothing requests)
//     found  out                  at least one request is set
// ----------------------------------------------------------------------------
module rr_pick #(
   parameter int N = 8
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         win_oh,
   output logic                 found
);

   localparam int ID_W  = $clog2(N);
   localparam int SUM_W = ID_W + 1;
   localparam logic [SUM_W-1:0] N_SUM = SUM_W'(N);

   // One extra bit so ptr + k (< 2N) never overflows before the wrap.
   logic [SUM_W-1:0] sum;
   logic [ID_W-1:0]  idx;

   always_comb begin
      win_oh = '0;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + SUM_W'(k);
         if (sum >= N_SUM) begin
            sum = sum - N_SUM;
         end
         idx = sum[ID_W-1:0];
         if (!found && req[idx]) begin
            win_oh[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_burst_scheduler.sv
// ----------------------------------------------------------------------------
// rr_burst_scheduler
//   Round-robin arbiter that holds each grant for a whole burst. A burst ends
//   on the granted requester's last beat or after MAX_BEATS accepted beats.
//   After a release there is always one idle bubble cycle before the next
//   grant. gnt_id is meant to drive the shared resource's input mux select.
//
//   Optional feature (macro GRANT_TIMEOUT_EN): a grant that sees TIMEOUT
//   consecutive BURST cycles without an accepted beat is released and abort
//   pulses for one cycle. Without the macro abort is tied low and a stalled
//   grant is held indefinitely.
//
//   Ports:
//     clk        in   clock, rising edge
//     reset_b    in   asynchronous active-low reset
//     req        in   [N-1:0] requester i has beat(s) pending
//     req_last   in   [N-1:0] requester i's current beat is its last
//     res_ready  in   shared resource accepts a beat this cycle
//     gnt        out  [N-1:0] one-hot grant, registered
//     gnt_id     out  [$clog2(N)-1:0] index of granted requester, registered
//     gnt_valid  out  a grant is active (|gnt)
//     beat_fire  out  combinational: beat accepted this cycle
//     beat_cnt   out  [$clog2(MAX_BEATS+1)-1:0] beats accepted this grant
//     abort      out  one-cycle pulse on timeout release
//
//   N must not exceed rr_burst_sched_pkg::MAX_N.
// ----------------------------------------------------------------------------
module rr_burst_scheduler
   import rr_burst_sched_pkg::*;
#(
   parameter int N         = 8,
   parameter int MAX_BEATS = DEF_MAX_BEATS,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic                             clk,
   input  logic                             reset_b,
   input  logic [N-1:0]                     req,
   input  logic [N-1:0]                     req_last,
   input  logic                             res_ready,
   output logic [N-1:0]                     gnt,
   output logic [$clog2(N)-1:0]             gnt_id,
   output logic                             gnt_valid,
   output logic                             beat_fire,
   output logic [$clog2(MAX_BEATS+1)-1:0]   beat_cnt,
   output logic                             abort
);

   localparam int ID_W  = $clog2(N);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BEATS);
   localparam logic [ID_W-1:0]  TOP_ID   = ID_W'(N - 1);

   state_e            state_q, state_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;

   logic [N-1:0]      pick_oh;
   logic              pick_found;
   logic              release_now;
   logic              timeout_hit;

   rr_pick #(.N(N)) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .win_oh (pick_oh),
      .found  (pick_found)
   );

   assign gnt_valid = |gnt_q;
   // Gating on req keeps a granted requester that has gone quiet from
   // producing phantom beats at the resource.
   assign beat_fire = gnt_valid & req[gnt_id_q] & res_ready;

`ifdef GRANT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

   logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
   logic            abort_q, abort_d;

   // A beat in the same cycle the limit is reached wins over the timeout.
   assign timeout_hit = (state_q == BURST) & ~beat_fire & (idle_cnt_q == TO_VAL);

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      abort_d    = timeout_hit;
      if (state_q != BURST || beat_fire || release_now) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q != TO_VAL) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         idle_cnt_q <= '0;
         abort_q    <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         abort_q    <= abort_d;
      end
   end

   assign abort = abort_q;
`else
   assign timeout_hit = 1'b0;
   assign abort       = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      beat_cnt_d  = beat_cnt_q;
      ptr_d       = ptr_q;
      release_now = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               gnt_d      = pick_oh;
               gnt_id_d   = ID_W'(onehot_to_idx(MAX_N'(pick_oh)));
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end

         BURST: begin
            if (beat_fire && beat_cnt_q != MAX_CNT) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
            // The beat that brings the count to MAX_BEATS is the last one.
            release_now = (beat_fire & (req_last[gnt_id_q] | (beat_cnt_q == LAST_CNT)))
                          | timeout_hit;
            if (release_now) begin
               gnt_d      = '0;
               beat_cnt_d = '0;
               ptr_d      = (gnt_id_q == TOP_ID) ? '0 : gnt_id_q + 1'b1;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         gnt_id_q   <= '0;
         beat_cnt_q <= '0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         beat_cnt_q <= beat_cnt_d;
         ptr_q      <= ptr_d;
      end
   end

   assign gnt      = gnt_q;
   assign gnt_id   = gnt_id_q;
   assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// ----------------------------------------------------------------------------
// tb_rr_burst_scheduler
//   Directed bench for rr_burst_scheduler with N=4, MAX_BEATS=4, TIMEOUT=8.
//   Inputs change 2 time units after each rising edge; outputs are sampled
//   one unit later, well away from the edge.
// ----------------------------------------------------------------------------
module tb_rr_burst_scheduler;

   logic       clk = 1'b0;
   logic       reset_b;
   logic [3:0] req;
   logic [3:0] req_last;
   logic       res_ready;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       beat_fire;
   logic [2:0] beat_cnt;
   logic       abort;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_burst_scheduler #(.N(4), .MAX_BEATS(4), .TIMEOUT(8)) dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .req       (req),
      .req_last  (req_last),
      .res_ready (res_ready),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .beat_fire (beat_fire),
      .beat_cnt  (beat_cnt),
      .abort     (abort)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset_b = 1'b0; req = '0; req_last = '0; res_ready = 1'b0;
      #3;
      checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 ||
          beat_cnt !== 3'd0 || abort !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got gnt=%b valid=%b id=%0d cnt=%0d abort=%b want all zero",
                  gnt, gnt_valid, gnt_id, beat_cnt, abort);
      end
      tick(); tick();
      reset_b = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         #1;
         checks++;
         if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_grant cycle %0d got gnt=%b valid=%b want 0000/0",
                     c, gnt, gnt_valid);
         end
      end
      $display("test_reset: idle for 10 cycles after reset");
   endtask

   // ptr=0; requester 2 bursts 3 beats, ending on req_last.
   task automatic test_basic_burst();
      req = 4'b0100; res_ready = 1'b1; req_last = '0;
      tick(); #1;
      checks++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || beat_cnt !== 3'd0) begin
         errors++;
         $display("FAIL basic_grant got gnt=%b id=%0d cnt=%0d want 0100/2/0", gnt, gnt_id, beat_cnt);
      end
      for (int b = 0; b < 3; b++) begin
         if (b == 2) req_last = 4'b0100;
         #1;
         checks++;
         if (beat_fire !== 1'b1 || beat_cnt !== 3'(b)) begin
            errors++;
            $display("FAIL basic_beat%0d got fire=%b cnt=%0d want 1/%0d", b, beat_fire, beat_cnt, b);
         end
         tick();
      end
      req = '0; req_last = '0;
      #1;
      checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || beat_cnt !== 3'd0 || beat_fire !== 1'b0) begin
         errors++;
         $display("FAIL basic_release got gnt=%b valid=%b cnt=%0d fire=%b want 0000/0/0/0",
                  gnt, gnt_valid, beat_cnt, beat_fire);
      end
      $display("test_basic_burst: id 2, 3 beats, released");
   endtask

   // ptr=3 after the basic burst, so order is 3,0,1,2,3 with a bubble each.
   task automatic test_fairness();
      logic [1:0] exp_id;
      req = 4'b1111; req_last = 4'b1111; res_ready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         exp_id = 2'((g + 3) % 4);
         tick(); #1;
         checks++;
         if (gnt_valid !== 1'b1 || gnt_id !== exp_id || gnt !== (4'b0001 << exp_id) ||
             beat_fire !== 1'b1) begin
            errors++;
            $display("FAIL fair_grant%0d got id=%0d gnt=%b fire=%b want id=%0d", g, gnt_id, gnt,
                     beat_fire, exp_id);
         end
         tick(); #1;
         checks++;
         if (gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL fair_bubble%0d got valid=%b want 0", g, gnt_valid);
         end
         $display("grant %0d -> id %0d", g, gnt_id);
      end
      req = '0; req_last = '0;
      tick();
   endtask

   // ptr=0; requesters 1 and 2, no req_last: forced release after 4 beats.
   task automatic test_forced_release();
      req = 4'b0110; req_last = '0; res_ready = 1'b1;
      tick(); #1;
      checks++;
      if (gnt_id !== 2'd1 || gnt_valid !== 1'b1) begin
         errors++;
         $display("FAIL forced_grant got id=%0d valid=%b want 1/1", gnt_id, gnt_valid);
      end
      for (int b = 0; b < 4; b++) begin
         checks++;
         if (beat_fire !== 1'b1 || beat_cnt !== 3'(b)) begin
            errors++;
            $display("FAIL forced_beat%0d got fire=%b cnt=%0d want 1/%0d", b, beat_fire, beat_cnt, b);
         end
         tick(); #1;
      end
      checks++;
      if (gnt_valid !== 1'b0 || beat_cnt !== 3'd0) begin
         errors++;
         $display("FAIL forced_release got valid=%b cnt=%0d want 0/0", gnt_valid, beat_cnt);
      end
      tick(); #1;
      checks++;
      if (gnt_id !== 2'd2 || gnt !== 4'b0100) begin
         errors++;
         $display("FAIL forced_next got id=%0d gnt=%b want 2/0100", gnt_id, gnt);
      end
      req_last = 4'b0100;
      tick();
      req = '0; req_last = '0;
      tick();
      $display("test_forced_release: 4 beats on id 1, next grant id 2");
   endtask

   // ptr=3; requester 3 under 1010 backpressure, then wrap to requester 0.
   task automatic test_backpressure_wrap();
      req = 4'b1001; req_last = '0; res_ready = 1'b1;
      tick();
      for (int c = 0; c < 7; c++) begin
         res_ready = (c % 2 == 0);
         #1;
         checks++;
         if (gnt_id !== 2'd3 || beat_fire !== res_ready || beat_cnt !== 3'((c + 1) / 2)) begin
            errors++;
            $display("FAIL bp_cycle%0d got id=%0d fire=%b cnt=%0d want 3/%b/%0d", c, gnt_id,
                     beat_fire, beat_cnt, res_ready, (c + 1) / 2);
         end
         tick();
      end
      res_ready = 1'b1;
      #1;
      checks++;
      if (gnt_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release got valid=%b want 0", gnt_valid);
      end
      tick(); #1;
      checks++;
      if (gnt_id !== 2'd0 || gnt !== 4'b0001) begin
         errors++;
         $display("FAIL bp_wrap got id=%0d gnt=%b want 0/0001", gnt_id, gnt);
      end
      req_last = 4'b0001;
      tick();
      req = '0; req_last = '0;
      tick();
      $display("test_backpressure_wrap: 4 beats over 7 cycles on id 3, wrap to id 0");
   endtask

   // ptr=1; requester 1 is granted and then drops req without req_last.
   task automatic test_stall();
      req = 4'b0010; req_last = '0; res_ready = 1'b1;
      tick();
      req = '0;
`ifdef GRANT_TIMEOUT_EN
      for (int c = 0; c < 11; c++) begin
         #1;
         checks++;
         if (gnt_valid !== (c < 9) || abort !== (c == 9) || beat_fire !== 1'b0) begin
            errors++;
            $display("FAIL stall_to%0d got valid=%b abort=%b fire=%b want %b/%b/0", c, gnt_valid,
                     abort, beat_fire, c < 9, c == 9);
         end
         tick();
      end
`else
      for (int c = 0; c < 11; c++) begin
         #1;
         checks++;
         if (gnt_valid !== 1'b1 || gnt_id !== 2'd1 || beat_fire !== 1'b0 ||
             beat_cnt !== 3'd0 || abort !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d got valid=%b id=%0d fire=%b cnt=%0d abort=%b want 1/1/0/0/0",
                     c, gnt_valid, gnt_id, beat_fire, beat_cnt, abort);
         end
         tick();
      end
      req = 4'b0010; req_last = 4'b0010;
      tick();
      req = '0; req_last = '0;
`endif
      tick();
      $display("test_stall: quiet requester held without beats");
   endtask

   // ptr=2; reset asserted after 2 beats of requester 2's burst.
   task automatic test_mid_burst_reset();
      req = 4'b1111; req_last = '0; res_ready = 1'b1;
      tick(); #1;
      checks++;
      if (gnt_id !== 2'd2) begin
         errors++;
         $display("FAIL mrst_grant got id=%0d want 2", gnt_id);
      end
      tick(); tick(); #1;
      checks++;
      if (beat_cnt !== 3'd2) begin
         errors++;
         $display("FAIL mrst_cnt got %0d want 2", beat_cnt);
      end
      #1;
      reset_b = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || beat_cnt !== 3'd0 || beat_fire !== 1'b0) begin
         errors++;
         $display("FAIL mrst_clear got gnt=%b valid=%b cnt=%0d fire=%b want 0000/0/0/0",
                  gnt, gnt_valid, beat_cnt, beat_fire);
      end
      #1;
      reset_b = 1'b1;
      tick(); #1;
      checks++;
      if (gnt_id !== 2'd0 || gnt !== 4'b0001) begin
         errors++;
         $display("FAIL mrst_ptr got id=%0d gnt=%b want 0/0001", gnt_id, gnt);
      end
      req = '0;
      tick();
      $display("test_mid_burst_reset: grant dropped, ptr back to 0");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_burst();
      test_fairness();
      test_forced_release();
      test_backpressure_wrap();
      test_stall();
      test_mid_burst_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_burst_scheduler.md
Name: rr_burst_scheduler

Overview:
- Shares one burst-oriented resource (bus port, memory bank) among N requesters with equal round-robin priority.
- A grant is held for a whole burst: it ends on the requester's last beat or when MAX_BEATS beats have been accepted, whichever comes first.
- Sits in front of the shared datapath; the requester index it outputs drives the resource's input mux select.

Parameters:
- N, 8, number of requesters; any value ≥ 2; power of two not required.
- MAX_BEATS, 16, maximum beats per grant before forced release; ≥ 1.
- TIMEOUT, 64, idle-beat cycles before grant abort; used only with GRANT_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_b  in  1  asynchronous active-low reset.
- req  in  N  requester i has beat(s) pending.
- req_last  in  N  requester i's current beat is the last of its burst.
- res_ready  in  1  shared resource accepts a beat this cycle.
- gnt  out  N  one-hot grant, registered.
- gnt_id  out  $clog2(N)  index of granted requester, registered.
- gnt_valid  out  1  a grant is active; equals |gnt.
- beat_fire  out  1  combinational: gnt_valid & req[gnt_id] & res_ready.
- beat_cnt  out  $clog2(MAX_BEATS+1)  beats accepted in the current grant.
- abort  out  1  one-cycle pulse on timeout release; tied 0 without the macro.

Behaviour:
- Reset state, applied asynchronously:
  - state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, beat_cnt=0, abort=0, ptr=0.
  - Reset during a burst drops the grant immediately. No beat is reported afterwards.
- FSM states: IDLE, BURST.
- IDLE, arbitration:
  - If |req, rotating-priority pick starts at ptr and searches upward, wrapping at N-1→0.
  - The first set bit wins. Next edge: gnt=onehot(winner), gnt_id=winner, beat_cnt=0, state=BURST.
  - Latency: req seen in IDLE at cycle t → gnt_valid at t+1.
  - If req=0: stay in IDLE; ptr unchanged.
- BURST:
  - Each beat_fire increments beat_cnt, saturating at MAX_BEATS.
  - Release condition: beat_fire & (req_last[gnt_id] | beat_cnt==MAX_BEATS-1).
  - On release, next edge: gnt=0, gnt_valid=0, ptr=(gnt_id+1) mod N, beat_cnt=0, state=IDLE.
  - Release at t → earliest new grant at t+2, giving exactly one idle bubble cycle.
- Changes to req of non-granted requesters during BURST are ignored; arbitration happens only in IDLE.
- Granted requester dropping req without req_last:
  - Grant is held and no beats are counted.
  - The resource must not see spurious beats; beat_fire already gates on req.
- MAX_BEATS=1: every accepted beat releases the grant, giving strict per-beat round-robin with a one-cycle bubble.
- Fairness: with all N requesting continuously, grants cycle 0,1,…,N-1,0,…. No requester waits more than N-1 grants.
- Invariants: gnt is always zero or one-hot; gnt_id is valid whenever gnt_valid=1.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - An idle counter counts BURST cycles without beat_fire and clears on each beat_fire.
  - When it reaches TIMEOUT, the next edge releases the grant exactly as a normal release (ptr advances, state=IDLE) and pulses abort for one cycle.
  - The counter resets to 0 on reset and on every grant.
- Undefined: no counter; abort is tied to 0; a stalled grant is held indefinitely.

Decomposition:
- Package rr_burst_sched_pkg holds:
  - the state enum typedef {IDLE, BURST};
  - the onehot-to-index function;
  - the default TIMEOUT/MAX_BEATS localparams.
- Sub-module rr_pick: purely combinational rotating-priority picker.
  - Inputs: req[N], ptr.
  - Outputs: one-hot winner and a found flag.
  - Instantiated once. Reusable by other arbiters in the codebase.

Test Plan:
- Reset/idle: hold reset_b=0, then release with req=0 → gnt=0, gnt_valid=0 for 10 cycles; ptr stays 0.
- Basic burst (N=4, MAX_BEATS=16): req=4'b0100 at t0, res_ready=1, req_last on the 3rd beat.
  - Expect gnt=4'b0100, gnt_id=2 at t0+1.
  - Expect 3 beat_fire cycles, gnt=0 on the cycle after the last beat, ptr=3.
- Fairness: req=4'b1111 constant, 1-beat bursts → grant order 0,1,2,3,0 with one bubble between grants.
- Forced release: MAX_BEATS=4, req_last never set → exactly 4 beat_fire, then release; next grant goes to the next active requester.
- Backpressure/wrap: gnt_id=3, res_ready toggling 1010…, req=4'b1001.
  - Beats are counted only when res_ready=1.
  - After release the next grant is id 0 (wrap).
- Mid-burst reset: assert reset_b=0 after 2 beats → gnt, beat_cnt, and ptr clear asynchronously.
  - With GRANT_TIMEOUT_EN and TIMEOUT=8, a stalled req produces abort after 8 idle cycles, followed by release.
